dac_sample_buffer: RTL and testbench

Sample buffer directly upstream of the codec DAC serializer. It accepts 24-bit mono samples from the DSP datapath over a valid/ready handshake and stores them in a FIFO. It presents a stable sample on the serializer's parallel input, and advances one entry per frame strobe (the serializer's sample-up pulse at left-channel start). It primes before playback, mutes on underrun, and reports fill level.

---
 rtl/codec_pkg.sv | 17 +
 rtl/sample_fifo_mem.sv | 44 ++++
 rtl/dac_sample_buffer.sv | 144 ++++++++++++++
 tb/tb_dac_sample_buffer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
// codec_pkg: shared types and constants for the codec DAC path.
//   SAMPLE_W     - serializer parallel sample width
//   buf_state_e  - sample buffer playback state (IDLE, PRIME, RUN)
//   MUTE_SAMPLE  - value driven to the serializer while muted
package codec_pkg;

  localparam int SAMPLE_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } buf_state_e;

  localparam logic [SAMPLE_W-1:0] MUTE_SAMPLE = '0;

endpackage

// File: rtl/sample_fifo_mem.sv
// sample_fifo_mem: DEPTH x DATA_W sample storage with read/write pointers.
// No flags; occupancy is tracked by the owner.
//   i_clk, i_rst  - clock, synchronous active-high reset
//   i_flush       - return both pointers to 0
//   i_wr_en/data  - push one entry
//   i_rd_en       - advance the read pointer
//   o_rd_data     - entry at the read pointer (head)
module sample_fifo_mem #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (i_wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (i_rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem_q[wr_ptr_q] <= i_wr_data;
  end

  assign o_rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/dac_sample_buffer.sv
// dac_sample_buffer: sample FIFO in front of the codec DAC serializer.
// Accepts samples over valid/ready, primes to PRIME_LVL entries, then pops
// one entry per serializer frame strobe; mutes and re-primes on underrun.
//   i_clk, i_rst         - MCLK, synchronous active-high reset
//   i_enable             - playback enable
//   i_s_data/valid/o_s_ready - upstream sample handshake
//   i_sample_up          - serializer frame strobe
//   o_p2s_out            - registered sample to serializer
//   o_level/o_almost_full/o_empty - occupancy status
//   o_underrun           - one-cycle pulse after an underrun strobe
// Optional macro DAC_BUF_STATS_EN adds o_underrun_cnt (saturating 16-bit).
module dac_sample_buffer
  import codec_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int DEPTH     = 16,
  parameter int PRIME_LVL = 8,
  parameter int AFULL_LVL = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic [DATA_W-1:0]        i_s_data,
  input  logic                     i_s_valid,
  output logic                     o_s_ready,
  input  logic                     i_sample_up,
  output logic [DATA_W-1:0]        o_p2s_out,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_almost_full,
  output logic                     o_empty,
  output logic                     o_underrun
`ifdef DAC_BUF_STATS_EN
  ,
  output logic [15:0]              o_underrun_cnt
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LVL);
  localparam logic [LW-1:0] AFULL_L = LW'(AFULL_LVL);

  buf_state_e        state_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  logic [DATA_W-1:0] p2s_q;
  logic              underrun_q;
  logic [DATA_W-1:0] head;
  logic              wr_en;
  logic              pop;
  logic              underrun_evt;
  logic              flush;

  assign o_s_ready    = (state_q != IDLE) && (level_q < DEPTH_L);
  assign wr_en        = i_s_valid && o_s_ready;
  assign pop          = i_enable && (state_q == RUN) && i_sample_up && (level_q != '0);
  // A write landing on an empty FIFO in the strobe cycle is still an underrun.
  assign underrun_evt = i_enable && (state_q == RUN) && i_sample_up && (level_q == '0);
  assign flush        = (state_q == IDLE) || !i_enable;

  always_comb begin
    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + 1'b1;
    else if (pop && !wr_en) level_d = level_q - 1'b1;
  end

  sample_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_flush   (flush),
    .i_wr_en   (wr_en),
    .i_wr_data (i_s_data),
    .i_rd_en   (pop),
    .o_rd_data (head)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      level_q    <= '0;
      p2s_q      <= MUTE_SAMPLE;
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= 1'b0;
      if (!i_enable) begin
        state_q <= IDLE;
        level_q <= '0;
        p2s_q   <= MUTE_SAMPLE;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= PRIME;
            level_q <= '0;
            p2s_q   <= MUTE_SAMPLE;
          end
          PRIME: begin
            level_q <= level_d;
            p2s_q   <= MUTE_SAMPLE;
            if (level_q >= PRIME_L) state_q <= RUN;
          end
          RUN: begin
            level_q <= level_d;
            if (underrun_evt) begin
              p2s_q      <= MUTE_SAMPLE;
              underrun_q <= 1'b1;
              state_q    <= PRIME;
            end else if (pop) begin
              p2s_q <= head;
            end
          end
          default: begin
            state_q <= IDLE;
            level_q <= '0;
            p2s_q   <= MUTE_SAMPLE;
          end
        endcase
      end
    end
  end

`ifdef DAC_BUF_STATS_EN
  logic [15:0] underrun_cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || state_q == IDLE) begin
      underrun_cnt_q <= '0;
    end else if (underrun_evt && underrun_cnt_q != 16'hFFFF) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign o_underrun_cnt = underrun_cnt_q;
`endif

  assign o_p2s_out     = p2s_q;
  assign o_level       = level_q;
  assign o_almost_full = level_q >= AFULL_L;
  assign o_empty       = level_q == '0;
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_dac_sample_buffer.sv
// Directed bench for dac_sample_buffer (default build; stats port checked
// when DAC_BUF_STATS_EN is defined).
module tb_dac_sample_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        sample_up;
  logic [23:0] p2s_out;
  logic [4:0]  level;
  logic        almost_full;
  logic        empty;
  logic        underrun;
`ifdef DAC_BUF_STATS_EN
  logic [15:0] underrun_cnt;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  always #41 clk = ~clk;

  dac_sample_buffer dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_s_data      (s_data),
    .i_s_valid     (s_valid),
    .o_s_ready     (s_ready),
    .i_sample_up   (sample_up),
    .o_p2s_out     (p2s_out),
    .o_level       (level),
    .o_almost_full (almost_full),
    .o_empty       (empty),
    .o_underrun    (underrun)
`ifdef DAC_BUF_STATS_EN
    ,
    .o_underrun_cnt(underrun_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; sample_up = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total_cnt++; if (level !== 5'd0) $display("FAIL reset_level got %0d exp 0", level); else pass_cnt++;
    total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else pass_cnt++;
    total_cnt++; if (almost_full !== 1'b0) $display("FAIL reset_afull got %b exp 0", almost_full); else pass_cnt++;
    total_cnt++; if (p2s_out !== 24'h0) $display("FAIL reset_p2s got %h exp 0", p2s_out); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b0) $display("FAIL reset_underrun got %b exp 0", underrun); else pass_cnt++;
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL idle_ready got %b exp 0", s_ready); else pass_cnt++;
    enable = 1'b1;
    tick();
    total_cnt++; if (s_ready !== 1'b1) $display("FAIL prime_ready got %b exp 1", s_ready); else pass_cnt++;
  endtask

  task automatic test_prime_and_play();
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1; s_data = 24'(i);
      tick();
    end
    s_valid = 1'b0;
    total_cnt++; if (level !== 5'd8) $display("FAIL prime_level got %0d exp 8", level); else pass_cnt++;
    tick();
    for (int i = 1; i <= 8; i++) begin
      sample_up = 1'b1;
      #1;
      total_cnt++; if (p2s_out !== 24'(i - 1)) $display("FAIL play_stable_%0d got %h exp %h", i, p2s_out, 24'(i - 1)); else pass_cnt++;
      tick();
      sample_up = 1'b0;
      total_cnt++; if (p2s_out !== 24'(i)) $display("FAIL play_pop_%0d got %h exp %h", i, p2s_out, 24'(i)); else pass_cnt++;
      tick();
    end
    total_cnt++; if (empty !== 1'b1 || level !== 5'd0) $display("FAIL play_drained level %0d exp 0", level); else pass_cnt++;
  endtask

  task automatic test_fill_full();
    for (int i = 1; i <= 16; i++) begin
      s_valid = 1'b1; s_data = 24'h100 + 24'(i - 1);
      tick();
      total_cnt++; if (level !== 5'(i)) $display("FAIL fill_level_%0d got %0d exp %0d", i, level, i); else pass_cnt++;
      total_cnt++; if (almost_full !== (i >= 12)) $display("FAIL fill_afull_%0d got %b exp %b", i, almost_full, (i >= 12)); else pass_cnt++;
    end
    total_cnt++; if (s_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", s_ready); else pass_cnt++;
    s_data = 24'h1FF;
    tick(); tick();
    total_cnt++; if (level !== 5'd16) $display("FAIL full_hold_level got %0d exp 16", level); else pass_cnt++;
    s_valid = 1'b0;
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 16; i++) begin
      sample_up = 1'b1;
      tick();
      sample_up = 1'b0;
      total_cnt++; if (p2s_out !== 24'h100 + 24'(i)) $display("FAIL drain_%0d got %h exp %h", i, p2s_out, 24'h100 + 24'(i)); else pass_cnt++;
    end
    sample_up = 1'b1;
    tick();
    sample_up = 1'b0;
    total_cnt++; if (p2s_out !== 24'h0) $display("FAIL underrun_mute got %h exp 0", p2s_out); else pass_cnt++;
    total_cnt++; if (underrun !== 1'b1) $display("FAIL underrun_pulse got %b exp 1", underrun); else pass_cnt++;
    tick();
    total_cnt++; if (underrun !== 1'b0) $display("FAIL underrun_single got %b exp 0", underrun); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 24'h200 + 24'(i);
      tick();
    end
    s_valid = 1'b0;
    sample_up = 1'b1;
    tick();
    sample_up = 1'b0;
    total_cnt++; if (p2s_out !== 24'h0 || level !== 5'd3) $display("FAIL prime_ignores_strobe p2s %h level %0d exp 0/3", p2s_out, level); else pass_cnt++;
    for (int i = 3; i < 8; i++) begin
      s_valid = 1'b1; s_data = 24'h200 + 24'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      sample_up = 1'b1;
      tick();
      sample_up = 1'b0;
      total_cnt++; if (p2s_out !== 24'h200 + 24'(i)) $display("FAIL reprime_pop_%0d got %h exp %h", i, p2s_out, 24'h200 + 24'(i)); else pass_cnt++;
    end
    total_cnt++; if (level !== 5'd5) $display("FAIL pre_simul_level got %0d exp 5", level); else pass_cnt++;
    s_valid = 1'b1; s_data = 24'h300; sample_up = 1'b1;
    tick();
    s_valid = 1'b0; sample_up = 1'b0;
    total_cnt++; if (level !== 5'd5) $display("FAIL simul_level got %0d exp 5", level); else pass_cnt++;
    total_cnt++; if (p2s_out !== 24'h203) $display("FAIL simul_pop got %h exp 203", p2s_out); else pass_cnt++;
  endtask

  task automatic test_disable();
    for (int i = 1; i <= 5; i++) begin
      s_valid = 1'b1; s_data = 24'h300 + 24'(i);
      tick();
    end
    s_valid = 1'b0;
    total_cnt++; if (level !== 5'd10) $display("FAIL pre_disable_level got %0d exp 10", level); else pass_cnt++;
    enable = 1'b0;
    tick();
    total_cnt++; if (level !== 5'd0 || p2s_out !== 24'h0 || s_ready !== 1'b0) $display("FAIL disable level %0d p2s %h ready %b exp 0/0/0", level, p2s_out, s_ready); else pass_cnt++;
    s_valid = 1'b1; s_data = 24'h3FF;
    tick(); tick();
    total_cnt++; if (level !== 5'd0) $display("FAIL idle_no_write got %0d exp 0", level); else pass_cnt++;
    s_valid = 1'b0;
    enable = 1'b1;
    tick();
    total_cnt++; if (s_ready !== 1'b1 || level !== 5'd0) $display("FAIL reenable ready %b level %0d exp 1/0", s_ready, level); else pass_cnt++;
    // Entries before the flush must not reappear.
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 24'h400 + 24'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    sample_up = 1'b1;
    tick();
    sample_up = 1'b0;
    total_cnt++; if (p2s_out !== 24'h400) $display("FAIL post_flush_head got %h exp 400", p2s_out); else pass_cnt++;
  endtask

  task automatic test_underrun_with_write();
    for (int i = 1; i < 8; i++) begin
      sample_up = 1'b1;
      tick();
      sample_up = 1'b0;
    end
    total_cnt++; if (p2s_out !== 24'h407 || level !== 5'd0) $display("FAIL drain2 p2s %h level %0d exp 407/0", p2s_out, level); else pass_cnt++;
    s_valid = 1'b1; s_data = 24'h555; sample_up = 1'b1;
    tick();
    s_valid = 1'b0; sample_up = 1'b0;
    total_cnt++; if (underrun !== 1'b1 || p2s_out !== 24'h0 || level !== 5'd1) $display("FAIL empty_write_strobe ur %b p2s %h level %0d exp 1/0/1", underrun, p2s_out, level); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = 24'h500 + 24'(i);
      tick();
    end
    s_valid = 1'b0;
    tick();
    sample_up = 1'b1;
    tick();
    sample_up = 1'b0;
    total_cnt++; if (p2s_out !== 24'h555) $display("FAIL mid_pre_pop got %h exp 555", p2s_out); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (p2s_out !== 24'h0 || level !== 5'd0 || empty !== 1'b1) $display("FAIL mid_reset p2s %h level %0d exp 0/0", p2s_out, level); else pass_cnt++;
    tick();
  endtask

`ifdef DAC_BUF_STATS_EN
  task automatic test_stats();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 8; i++) begin
        s_valid = 1'b1; s_data = 24'h600 + 24'(i);
        tick();
      end
      s_valid = 1'b0;
      tick();
      for (int i = 0; i < 9; i++) begin
        sample_up = 1'b1;
        tick();
        sample_up = 1'b0;
      end
    end
    total_cnt++; if (underrun_cnt !== 16'd3) $display("FAIL stats_count got %0d exp 3", underrun_cnt); else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total_cnt++; if (underrun_cnt !== 16'd0) $display("FAIL stats_reset got %0d exp 0", underrun_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    rst = 1'b1; enable = 1'b0; s_valid = 1'b0; s_data = '0; sample_up = 1'b0;
    test_reset();
    test_prime_and_play();
    test_fill_full();
    test_underrun();
    test_back_to_back();
    test_disable();
    test_underrun_with_write();
    test_reset_mid();
`ifdef DAC_BUF_STATS_EN
    enable = 1'b1;
    tick();
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
